softmax_row_arbiter: RTL

SOFTMAX_ROW_ARBITER -- requirements
Module: softmax_row_arbiter

---
 rtl/softmax_pkg.sv | 19 +
 rtl/sm_return_fifo.sv | 60 ++++++
 rtl/softmax_row_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax row arbiter: default sizes, the row
// type and the pointer-width helper used by the arbiter and its return FIFO.
package softmax_pkg;

    localparam int DEF_N         = 32;
    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_DEPTH     = 4;

    // One row of N elements at the default sizes; element 0 in the low bits.
    typedef logic [DEF_N-1:0][DEF_BIT_WIDTH-1:0] row_t;

    // Pointer width for a DEPTH-entry circular buffer (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);

endpackage

// File: rtl/sm_return_fifo.sv
// First-word-fall-through FIFO holding {tag, result row} until the consumer
// takes it. DEPTH is a power of two, so the pointers wrap naturally.
module sm_return_fifo
    import softmax_pkg::*;
#(
    parameter int WIDTH = DEF_N * DEF_BIT_WIDTH + 1,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop_ok;

    // A pop on an empty FIFO is ignored so the count can never underflow.
    assign pop_ok    = pop && (count_reg != '0);
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    // Storage is not reset; only the pointers and the count decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/softmax_row_arbiter.sv
// Two-requester round-robin front end for a softmax datapath. Rows are issued
// only when a return-FIFO slot is guaranteed (credits), the source of every
// issued row is remembered in an in-order tag queue, and results come back
// through a FWFT return FIFO tagged with their requester.
module softmax_row_arbiter
    import softmax_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [1:0]                          i_req_valid,
    input  logic [1:0][N-1:0][BIT_WIDTH-1:0]    i_req_data,
    output logic [1:0]                          o_req_ready,
    output logic                                o_sm_valid,
    output logic [N-1:0][BIT_WIDTH-1:0]         o_sm_data,
    input  logic                                i_sm_valid,
    input  logic [N-1:0][BIT_WIDTH-1:0]         i_sm_data,
    output logic                                o_valid,
    output logic [N-1:0][BIT_WIDTH-1:0]         o_data,
    output logic                                o_src,
    input  logic                                i_ready,
    output logic                                o_err
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ROW_W = N * BIT_WIDTH;

    logic                         rr_reg;
    logic [CNT_W-1:0]             inflight_reg;
    logic                         tag_mem [DEPTH];
    logic [PTR_W-1:0]             tag_wr_ptr_reg;
    logic [PTR_W-1:0]             tag_rd_ptr_reg;
    logic                         sm_valid_reg;
    logic [N-1:0][BIT_WIDTH-1:0]  sm_data_reg;
    logic                         err_reg;

    logic [CNT_W-1:0]             fifo_count;
    logic [CNT_W-1:0]             credits;
    logic                         has_credit;
    logic                         grant;
    logic                         both_valid;
    logic                         accept;
    logic                         ret_fire;
    logic                         ret_err;
    logic                         pop;
    logic [ROW_W:0]               head_word;

    // Credits come from registered counters only, so a pop frees a slot
    // for acceptance in the following cycle, never the same one.
    assign credits    = CNT_W'(DEPTH) - (fifo_count + inflight_reg);
    assign has_credit = (credits != '0);

    // Round-robin: a lone requester wins outright, contention goes to rr.
    assign both_valid = (i_req_valid == 2'b11);
    assign grant      = both_valid ? rr_reg : i_req_valid[1];

    // Ready is held low while reset is asserted so nothing is accepted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign o_req_ready[gi] = i_rst_n && has_credit && i_req_valid[gi]
                                     && (grant == (gi == 1));
        end
    endgenerate

    assign accept   = |o_req_ready;
    assign ret_fire = i_sm_valid && (inflight_reg != '0);
    assign ret_err  = i_sm_valid && (inflight_reg == '0);
    assign pop      = o_valid && i_ready;

    assign o_valid    = (fifo_count != '0);
    assign o_src      = head_word[ROW_W];
    assign o_data     = head_word[ROW_W-1:0];
    assign o_sm_valid = sm_valid_reg;
    assign o_sm_data  = sm_data_reg;
    assign o_err      = err_reg;

    // Tag queue storage: the winning requester index of each issued row.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            tag_mem[tag_wr_ptr_reg] <= grant;
        end
    end

    // Issue register, arbitration pointer, tag pointers, in-flight count and
    // the sticky error flag. A stray result is dropped without touching state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_reg         <= 1'b0;
            inflight_reg   <= '0;
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            sm_valid_reg   <= 1'b0;
            sm_data_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            sm_valid_reg <= accept;
            if (accept) begin
                sm_data_reg    <= i_req_data[grant];
                tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(1);
                if (both_valid) begin
                    rr_reg <= ~grant;
                end
            end
            if (ret_fire) begin
                tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_W'(1);
            end
            case ({accept, ret_fire})
                2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            if (ret_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    sm_return_fifo #(
        .WIDTH (ROW_W + 1),
        .DEPTH (DEPTH)
    ) u_return_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (ret_fire),
        .push_data ({tag_mem[tag_rd_ptr_reg], i_sm_data}),
        .pop       (pop),
        .head_data (head_word),
        .count     (fifo_count)
    );

endmodule
